// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage core: writeback-select encodings,
// register address width and the hazard-controller state type.
// Ports: none (package).
package core_pkg;

  // Register file address width (x0..x31)
  localparam int REG_AW = 5;

  // Writeback select encodings for the EX stage
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Hazard controller FSM state, kept as plain constants for legacy tools
  typedef logic [1:0] hz_state_t;
  localparam hz_state_t HZ_RUN      = 2'd0;
  localparam hz_state_t HZ_MEM_WAIT = 2'd1;
  localparam hz_state_t HZ_FLUSH    = 2'd2;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently in EX. Purely combinational, 0 latency.
// Ports: i_id_rs1addr/i_id_rs2addr/i_id_uses_rs1/i_id_uses_rs2 (ID sources),
//        i_ex_rdaddr/i_ex_regwr/i_ex_wbsel (EX producer), o_load_use.
module hazard_detect
  import core_pkg::*;
(
  input  logic [REG_AW-1:0] i_id_rs1addr,
  input  logic [REG_AW-1:0] i_id_rs2addr,
  input  logic              i_id_uses_rs1,
  input  logic              i_id_uses_rs2,
  input  logic [REG_AW-1:0] i_ex_rdaddr,
  input  logic              i_ex_regwr,
  input  logic [1:0]        i_ex_wbsel,
  output logic              o_load_use
);

  logic w_ex_is_load;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign w_ex_is_load = i_ex_regwr && (i_ex_wbsel == WB_MEM) && (i_ex_rdaddr != '0);
  assign w_rs1_hit    = i_id_uses_rs1 && (i_id_rs1addr == i_ex_rdaddr);
  assign w_rs2_hit    = i_id_uses_rs2 && (i_id_rs2addr == i_ex_rdaddr);
  assign o_load_use   = w_ex_is_load && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: sequences stall/bubble/flush/redirect for
// PC, IF/ID, ID/EX and EX/MEM; keeps saturating stall and flush counters.
// Ports: clk, rst (async active-low); ID/EX hazard inputs; mem_req/mem_ack;
//        Mealy control outputs (0 latency); mem_timeout_err; stall_cnt/flush_cnt.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1addr,
  input  logic [REG_AW-1:0] id_rs2addr,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rdaddr,
  input  logic              ex_regwr,
  input  logic [1:0]        ex_wbsel,
  input  logic              ex_br_taken,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_stall,
  output logic              exmem_stall,
  output logic              pc_redirect,
  output logic              mem_timeout_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // The redirect cycle is the first bubble; FLUSH covers the remaining
  // FLUSH_CYCLES-1 cycles, so the down-counter is loaded with FLUSH_CYCLES-2.
  localparam int         FLUSH_LOAD_I = (FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0;
  localparam logic [1:0] FLUSH_LOAD   = FLUSH_LOAD_I[1:0];

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_TRIP = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  hz_state_t         r_state;
  logic [1:0]        r_flush_left;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_err;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  hz_state_t  w_state_nxt;
  logic [1:0] w_flush_left_nxt;
  logic       w_load_use;
  logic       w_mem_stall;
  logic       w_pc_stall;
  logic       w_ifid_stall;
  logic       w_ifid_flush;
  logic       w_idex_stall;
  logic       w_exmem_stall;
  logic       w_pc_redirect;

  hazard_detect u_hazard_detect (
    .i_id_rs1addr  (id_rs1addr),
    .i_id_rs2addr  (id_rs2addr),
    .i_id_uses_rs1 (id_uses_rs1),
    .i_id_uses_rs2 (id_uses_rs2),
    .i_ex_rdaddr   (ex_rdaddr),
    .i_ex_regwr    (ex_regwr),
    .i_ex_wbsel    (ex_wbsel),
    .o_load_use    (w_load_use)
  );

  // An access acknowledged in the same cycle it is presented costs nothing
  assign w_mem_stall = mem_req && !mem_ack;

  always_comb begin
    w_state_nxt      = r_state;
    w_flush_left_nxt = r_flush_left;
    w_pc_stall       = 1'b0;
    w_ifid_stall     = 1'b0;
    w_ifid_flush     = 1'b0;
    w_idex_stall     = 1'b0;
    w_exmem_stall    = 1'b0;
    w_pc_redirect    = 1'b0;

    case (r_state)
      HZ_RUN: begin
        if (w_mem_stall) begin
          // Freeze the whole front end; a branch sitting in EX is held, not taken
          w_pc_stall    = 1'b1;
          w_ifid_stall  = 1'b1;
          w_idex_stall  = 1'b1;
          w_exmem_stall = 1'b1;
          w_state_nxt   = HZ_MEM_WAIT;
        end else if (ex_br_taken) begin
          // The ID instruction is wrong-path, so any load-use on it is moot
          w_pc_redirect = 1'b1;
          w_ifid_flush  = 1'b1;
          w_idex_stall  = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_state_nxt      = HZ_FLUSH;
            w_flush_left_nxt = FLUSH_LOAD;
          end
        end else if (w_load_use) begin
          // One cycle is enough: next cycle the load is in MEM and forwards
          w_pc_stall   = 1'b1;
          w_ifid_stall = 1'b1;
          w_idex_stall = 1'b1;
        end
      end

      HZ_MEM_WAIT: begin
        if (!mem_ack) begin
          w_pc_stall    = 1'b1;
          w_ifid_stall  = 1'b1;
          w_idex_stall  = 1'b1;
          w_exmem_stall = 1'b1;
        end else begin
          // Branch and load-use are re-examined only once back in RUN
          w_state_nxt = HZ_RUN;
        end
      end

      HZ_FLUSH: begin
        if (w_mem_stall) begin
          w_pc_stall       = 1'b1;
          w_ifid_stall     = 1'b1;
          w_idex_stall     = 1'b1;
          w_exmem_stall    = 1'b1;
          w_state_nxt      = HZ_MEM_WAIT;
          w_flush_left_nxt = 2'd0;
        end else begin
          w_ifid_flush = 1'b1;
          w_idex_stall = 1'b1;
          if (r_flush_left == 2'd0) begin
            w_state_nxt = HZ_RUN;
          end else begin
            w_flush_left_nxt = r_flush_left - 2'd1;
          end
        end
      end

      default: begin
        w_state_nxt      = HZ_RUN;
        w_flush_left_nxt = 2'd0;
      end
    endcase
  end

  // While reset is asserted every control is forced low, independent of inputs
  assign pc_stall        = w_pc_stall    && rst;
  assign ifid_stall      = w_ifid_stall  && rst;
  assign ifid_flush      = w_ifid_flush  && rst;
  assign idex_stall      = w_idex_stall  && rst;
  assign exmem_stall     = w_exmem_stall && rst;
  assign pc_redirect     = w_pc_redirect && rst;
  assign mem_timeout_err = r_err;
  assign stall_cnt       = r_stall_cnt;
  assign flush_cnt       = r_flush_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= HZ_RUN;
      r_flush_left <= 2'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_left <= w_flush_left_nxt;
    end
  end

  // Wait counter runs only in MEM_WAIT; it stops at MEM_TIMEOUT so it cannot
  // wrap, and the error flag is sticky until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else if (r_state == HZ_MEM_WAIT) begin
      if (r_wait_cnt != WAIT_MAX) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
      if (r_wait_cnt == WAIT_TRIP) begin
        r_err <= 1'b1;
      end
    end else begin
      r_wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_pc_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (w_pc_redirect && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios followed by randomized traffic,
// each cycle compared against a behavioural pipeline-control model.
// Ports: none (top-level bench).
module tb_hazard_ctrl;

  localparam int FC  = 2;
  localparam int TMO = 8;
  localparam int CW  = 6;
  localparam longint CMAX = (64'd1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs1addr, id_rs2addr, ex_rdaddr;
  logic          id_uses_rs1, id_uses_rs2, ex_regwr, ex_br_taken, mem_req, mem_ack;
  logic [1:0]    ex_wbsel;
  logic          pc_stall, ifid_stall, ifid_flush, idex_stall, exmem_stall, pc_redirect;
  logic          mem_timeout_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1addr(id_rs1addr), .id_rs2addr(id_rs2addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rdaddr(ex_rdaddr), .ex_regwr(ex_regwr), .ex_wbsel(ex_wbsel),
    .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .exmem_stall(exmem_stall), .pc_redirect(pc_redirect),
    .mem_timeout_err(mem_timeout_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural model: "waiting" for memory, number of bubble cycles still owed
  // after a redirect, MEM_WAIT cycles elapsed, sticky error, event counters.
  bit     m_wait;
  int     m_bubbles;
  int     m_waited;
  bit     m_err;
  longint m_stalls;
  longint m_flushes;

  // Pending next-cycle model values, committed at the clock edge
  bit     n_wait;
  int     n_bubbles;
  int     n_waited;
  bit     n_err;
  logic [5:0] e_out; // {pc_stall, ifid_stall, ifid_flush, idex_stall, exmem_stall, pc_redirect}

  task automatic model_reset();
    m_wait = 0; m_bubbles = 0; m_waited = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic model_eval();
    bit lu, ms;
    lu = ex_regwr && ex_wbsel == 2'b01 && ex_rdaddr != 0 &&
         ((id_uses_rs1 && id_rs1addr == ex_rdaddr) || (id_uses_rs2 && id_rs2addr == ex_rdaddr));
    ms = mem_req && !mem_ack;
    e_out = 6'b0;
    n_wait = m_wait; n_bubbles = m_bubbles; n_waited = 0; n_err = m_err;
    if (m_wait) begin
      n_waited = m_waited + 1;
      if (n_waited >= TMO) n_err = 1;
      if (!mem_ack) e_out = 6'b110110;
      else begin n_wait = 0; n_waited = 0; end
    end else if (m_bubbles > 0) begin
      if (ms) begin e_out = 6'b110110; n_wait = 1; n_bubbles = 0; end
      else begin e_out = 6'b001100; n_bubbles = m_bubbles - 1; end
    end else if (ms) begin
      e_out = 6'b110110; n_wait = 1;
    end else if (ex_br_taken) begin
      e_out = 6'b001101; n_bubbles = FC - 1;
    end else if (lu) begin
      e_out = 6'b110100;
    end
  endtask

  task automatic model_commit();
    if (e_out[5] && m_stalls < CMAX) m_stalls++;
    if (e_out[0] && m_flushes < CMAX) m_flushes++;
    m_wait = n_wait; m_bubbles = n_bubbles; m_waited = n_waited; m_err = n_err;
  endtask

  // One clock: compare mid-cycle on the falling edge, advance model on the rising edge
  task automatic cycle();
    @(negedge clk);
    model_eval();
    chk("pc_stall",    {63'b0, pc_stall},    {63'b0, e_out[5]});
    chk("ifid_stall",  {63'b0, ifid_stall},  {63'b0, e_out[4]});
    chk("ifid_flush",  {63'b0, ifid_flush},  {63'b0, e_out[3]});
    chk("idex_stall",  {63'b0, idex_stall},  {63'b0, e_out[2]});
    chk("exmem_stall", {63'b0, exmem_stall}, {63'b0, e_out[1]});
    chk("pc_redirect", {63'b0, pc_redirect}, {63'b0, e_out[0]});
    chk("timeout_err", {63'b0, mem_timeout_err}, {63'b0, m_err});
    chk("stall_cnt",   64'(stall_cnt), 64'(m_stalls));
    chk("flush_cnt",   64'(flush_cnt), 64'(m_flushes));
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1addr = 0; id_rs2addr = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rdaddr = 0; ex_regwr = 0; ex_wbsel = 2'b00; ex_br_taken = 0;
    mem_req = 0; mem_ack = 0;
  endtask

  // Assert reset between edges and check that everything clears at once
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk({tag, "_pc_stall"},    {63'b0, pc_stall},    64'd0);
    chk({tag, "_ifid_stall"},  {63'b0, ifid_stall},  64'd0);
    chk({tag, "_ifid_flush"},  {63'b0, ifid_flush},  64'd0);
    chk({tag, "_idex_stall"},  {63'b0, idex_stall},  64'd0);
    chk({tag, "_exmem_stall"}, {63'b0, exmem_stall}, 64'd0);
    chk({tag, "_pc_redirect"}, {63'b0, pc_redirect}, 64'd0);
    chk({tag, "_err"},         {63'b0, mem_timeout_err}, 64'd0);
    chk({tag, "_stall_cnt"},   64'(stall_cnt), 64'd0);
    chk({tag, "_flush_cnt"},   64'(flush_cnt), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_wbsel = 2'b01; ex_regwr = 1; ex_rdaddr = rd;
    id_rs2addr = rd; id_uses_rs2 = 1; id_rs1addr = 5'd9; id_uses_rs1 = 1;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state
    cycle();
    chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);

    // Load-use on rs2: one stall cycle only
    set_load_use(5'd5);
    cycle();
    idle_inputs();
    cycle();
    chk("loaduse_stall_cnt", 64'(stall_cnt), 64'd1);

    // Load into x0: no hazard
    set_load_use(5'd0);
    cycle();
    idle_inputs();
    chk("x0_stall_cnt", 64'(stall_cnt), 64'd1);

    // Branch taken together with a load-use: two bubbles, no pc_stall
    do_reset("rst1");
    set_load_use(5'd7);
    ex_br_taken = 1;
    cycle();
    idle_inputs();
    cycle();
    cycle();
    chk("branch_flush_cnt", 64'(flush_cnt), 64'd1);
    chk("branch_stall_cnt", 64'(stall_cnt), 64'd0);

    // Mem wait: 4 stalled cycles, released on ack
    do_reset("rst2");
    mem_req = 1; mem_ack = 0;
    repeat (4) cycle();
    mem_ack = 1;
    cycle();
    idle_inputs();
    cycle();
    chk("memwait_stall_cnt", 64'(stall_cnt), 64'd4);

    // Mem wait holding off a taken branch; redirect the cycle after the ack
    do_reset("rst3");
    mem_req = 1; mem_ack = 0; ex_br_taken = 1;
    repeat (3) cycle();
    mem_ack = 1;
    cycle();
    chk("membr_no_redirect", 64'(flush_cnt), 64'd0);
    mem_req = 0; mem_ack = 0;
    cycle();
    chk("membr_redirect_after_ack", 64'(flush_cnt), 64'd1);
    idle_inputs();
    repeat (2) cycle();

    // Timeout: one RUN entry cycle plus TMO wait cycles, then the flag is up
    do_reset("rst4");
    mem_req = 1; mem_ack = 0;
    repeat (TMO) cycle();
    chk("timeout_not_yet", {63'b0, mem_timeout_err}, 64'd0);
    cycle();
    chk("timeout_set", {63'b0, mem_timeout_err}, 64'd1);
    repeat (3) cycle();
    chk("timeout_sticky", {63'b0, mem_timeout_err}, 64'd1);
    // Reset while still waiting with the request held
    do_reset("rst_midwait");
    idle_inputs();
    cycle();

    // Randomized traffic with a small register range so hazards are frequent
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        do_reset("rst_rand");
      end
      id_rs1addr  = 5'($urandom_range(0, 3));
      id_rs2addr  = 5'($urandom_range(0, 3));
      ex_rdaddr   = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom_range(0, 1));
      id_uses_rs2 = 1'($urandom_range(0, 1));
      ex_regwr    = 1'($urandom_range(0, 3) != 0);
      ex_wbsel    = 2'($urandom_range(0, 2));
      ex_br_taken = 1'($urandom_range(0, 5) == 0);
      if (m_wait) begin
        mem_req = 1;
        mem_ack = 1'($urandom_range(0, 3) == 0);
      end else begin
        mem_req = 1'($urandom_range(0, 3) == 0);
        mem_ack = 1'($urandom_range(0, 1));
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
